// File: rtl/ice51_pkg.sv
// rtl/ice51_pkg.sv - shared types and constants for the ice51 UART boot loader
package ice51_pkg;

  localparam int         MEM_DEPTH_DEF = 512;
  localparam logic [7:0] ACK           = 8'hA5;
  localparam logic [7:0] NAK           = 8'h5A;

  typedef logic [8:0] code_addr_t;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_REPLY,
    ST_RUN
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/ice51_uart_rx.sv
// rtl/ice51_uart_rx.sv - 8N1 UART receiver with synchroniser, mid-bit sampling and framing check
module ice51_uart_rx
  import ice51_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int            TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  rx_state_e     st_q, st_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      st_q    <= st_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    sync1_d = i_rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    st_d    = st_q;
    timer_d = timer_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        timer_d = '0;
        if (prev_q && !sync2_q) st_d = RX_START;
      end
      RX_START: begin
        // Half-bit recheck rejects short glitches and aligns later samples to bit centres
        if (timer_q == T_HALF) begin
          timer_d = '0;
          bit_d   = '0;
          st_d    = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          st_d    = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/ice51_loader.sv
// rtl/ice51_loader.sv - UART boot loader: length-prefixed image into code RAM, status reply, core release
module ice51_loader
  import ice51_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int MEM_DEPTH    = MEM_DEPTH_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic       o_code_wr,
  output logic [8:0] o_code_addr,
  output logic [7:0] o_code_data,
  output logic       o_core_nrst,
  output logic       o_busy
);

  localparam int            TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  ice51_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_uart_rx),
    .o_data     (rx_data),
    .o_valid    (rx_valid),
    .o_frame_err(rx_ferr)
  );

  loader_state_e state_q, state_d;
  logic [15:0]   len_q, len_d;
  code_addr_t    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic          err_q, err_d;
  logic          bad_len_q, bad_len_d;
  logic          wr_q, wr_d;
  code_addr_t    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          tx_q, tx_d;
  logic          tx_act_q, tx_act_d;
  logic [18:0]   tx_shift_q, tx_shift_d;
  logic [4:0]    tx_bits_q, tx_bits_d;
  logic [TW-1:0] tx_timer_q, tx_timer_d;

  logic [15:0] len_full;
  logic [7:0]  status;

  assign len_full = {len_q[15:8], rx_data};
  assign status   = (err_q || bad_len_q) ? NAK : ACK;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_LEN_HI;
      len_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      err_q      <= 1'b0;
      bad_len_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_q       <= 1'b1;
      tx_act_q   <= 1'b0;
      tx_shift_q <= '1;
      tx_bits_q  <= '0;
      tx_timer_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      bad_len_q  <= bad_len_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_q       <= tx_d;
      tx_act_q   <= tx_act_d;
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      tx_timer_q <= tx_timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    err_d      = err_q;
    bad_len_d  = bad_len_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_d       = tx_q;
    tx_act_d   = tx_act_q;
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_timer_d = tx_timer_q;
    case (state_q)
      ST_LEN_HI: begin
        cnt_d     = '0;
        sum_d     = '0;
        err_d     = 1'b0;
        bad_len_d = 1'b0;
        if (rx_valid) begin
          len_d   = {rx_data, 8'h00};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_ferr) err_d = 1'b1;
        if (rx_valid) begin
          len_d = len_full;
          if (len_full == 16'd0 || len_full > 16'(MEM_DEPTH)) begin
            bad_len_d = 1'b1;
            state_d   = ST_REPLY;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_ferr) err_d = 1'b1;
        if (rx_valid) begin
          wr_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = rx_data;
          cnt_d   = cnt_q + 9'd1;
          sum_d   = sum_q + rx_data;
          if (len_q == 16'(cnt_q) + 16'd1) state_d = ST_REPLY;
        end
      end
      ST_REPLY: begin
        // Both reply bytes go out as one 20-bit frame: start, status, stop, start, sum, stop
        if (!tx_act_q) begin
          tx_act_d   = 1'b1;
          tx_d       = 1'b0;
          tx_shift_d = {1'b1, sum_q, 1'b0, 1'b1, status};
          tx_bits_d  = 5'd19;
          tx_timer_d = '0;
        end else if (tx_timer_q == T_LAST) begin
          tx_timer_d = '0;
          if (tx_bits_q == 5'd0) begin
            tx_act_d = 1'b0;
            state_d  = (err_q || bad_len_q) ? ST_LEN_HI : ST_RUN;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[18:1]};
            tx_bits_d  = tx_bits_q - 5'd1;
          end
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_LEN_HI;
    endcase
  end

  assign o_uart_tx   = tx_q;
  assign o_code_wr   = wr_q;
  assign o_code_addr = addr_q;
  assign o_code_data = wdata_q;
  assign o_core_nrst = (state_q == ST_RUN);
  assign o_busy      = (state_q == ST_LEN_LO) || (state_q == ST_DATA) || (state_q == ST_REPLY);

endmodule

// File: doc/ice51_loader.md
# ice51_loader

UART boot loader that sits directly upstream of the ice51 code memory. It holds the core in reset and receives a length-prefixed program image over UART. It writes the image byte-by-byte into the 512x8 code RAM from address 0, returns a status/checksum reply, then releases the core.

## Interface
Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); must be ≥ 8
- MEM_DEPTH, 512, code memory depth in bytes; maximum accepted image length

Ports:
- i_clk  in  1  system clock; the only clock
- i_rst  in  1  reset, synchronous, active-high
- i_uart_rx  in  1  UART receive line, asynchronous, idle high
- o_uart_tx  out  1  UART transmit line, idle high
- o_code_wr  out  1  code memory write strobe, one-cycle pulse
- o_code_addr  out  9  code memory write address
- o_code_data  out  8  code memory write data
- o_core_nrst  out  1  core reset, active-low; 0 while loading, 1 once released
- o_busy  out  1  high from the first length byte until the reply's last stop bit

## Operation
- UART format: 8N1, LSB first.
- RX path:
  - 2-flop synchroniser.
  - A falling edge in idle starts a frame.
  - Start bit re-checked at CLKS_PER_BIT/2; if it is high, return to idle (glitch).
  - Data bits sampled every CLKS_PER_BIT after that point.
  - A stop bit sampled low is a framing error: byte discarded, sticky error flag set.
- Protocol: LEN_HI byte, LEN_LO byte (16-bit big-endian length N), then N payload bytes, then reply.
- States: LEN_HI → LEN_LO → DATA → REPLY → RUN.
  - LEN_HI: wait for a byte; clear addr, sum, error flag.
  - LEN_LO: form N.
    - If N == 0 or N > MEM_DEPTH: go to REPLY with status 0x5A, checksum 0x00, then return to LEN_HI (not RUN).
    - Otherwise go to DATA.
  - DATA: each valid byte is written at addr, then addr increments and the 8-bit sum accumulates (mod 256). After byte N go to REPLY.
  - REPLY: transmit status byte (0xA5 = ok, 0x5A = error), then the checksum byte.
    - Error flag set → status 0x5A, then back to LEN_HI; the core stays in reset.
    - Otherwise → RUN.
  - RUN: o_core_nrst = 1. RX is ignored until i_rst.
- Framing errors in DATA do not write memory and do not advance the count; the host must re-send the whole image after the 0x5A reply. A transfer containing an errored byte will hang in DATA until more bytes arrive. The host must send exactly N good bytes.
- Address arithmetic is 9-bit. N == 512 writes addresses 0..511; no wrap occurs because N ≤ MEM_DEPTH.

## Timing
- Reset values: o_uart_tx = 1, o_code_wr = 0, o_code_addr = 0, o_code_data = 0, o_core_nrst = 0, o_busy = 0. State = LEN_HI; counters, sum and error flag cleared.
- Byte-valid pulse is asserted in the cycle after the stop-bit sample (mid stop bit).
- o_code_wr pulses exactly one cycle, the cycle after byte-valid. o_code_addr and o_code_data are stable in that cycle and hold until the next write.
- The REPLY TX start bit begins 1 cycle after the final write pulse (or after LEN_LO for a bad length). Each bit lasts CLKS_PER_BIT cycles. The two reply bytes are back-to-back: 20 bit times total.
- o_core_nrst rises the cycle after the checksum byte's stop bit completes; o_busy falls in the same cycle.
- RX remains active during REPLY when returning to LEN_HI. Bytes received during REPLY are dropped.
- i_rst mid-operation: all state returns to reset values on the next edge. Memory already written is left as is. Any TX frame in progress is truncated (line driven high).

## Structure
- Package ice51_pkg holds:
  - the loader state enum
  - ACK/NAK constants (0xA5, 0x5A)
  - MEM_DEPTH default
  - the 9-bit code address typedef
- One sub-module: ice51_uart_rx. It contains the synchroniser, bit timer and framing check, and outputs an 8-bit byte, a valid pulse and a framing-error pulse.
- TX shifter and protocol FSM live in ice51_loader. Target ~250 lines total.

## Test plan
- Length 4, payload 0x02,0x00,0x10,0xFF:
  - four o_code_wr pulses at addresses 0..3 with those data
  - reply 0xA5, 0x11
  - o_core_nrst rises after the reply
- Length 512, bytes i & 0xFF:
  - last write at addr 511 with data 0xFF
  - checksum 0x00 (sum of 2×(0..255) mod 256)
  - status 0xA5
- Length 0x0000, then length 0x0201:
  - each produces reply 0x5A, 0x00 with no writes; o_core_nrst stays 0
  - a following valid length-1 load succeeds
- Length 2, first payload byte sent with stop bit low, then two good bytes 0x01,0x02:
  - only 0x01@0 and 0x02@1 are written
  - reply 0x5A, 0x03; core stays in reset
- Glitch of CLKS_PER_BIT/4 low on RX in idle → no byte accepted, state stays LEN_HI.
- Assert i_rst mid-DATA (after 2 of 4 bytes) → all outputs at reset values next cycle; a fresh load of length 1 then completes with 0xA5.
